// File: rtl/spi_request_arbiter.sv
// spi_request_arbiter
//   Shares one Avalon-MM spi_master among NUM_REQ requesters. A round-robin
//   arbiter picks one request. The FSM then writes the transmit word, writes
//   the slave select to start the transfer, waits XFER_CYCLES, reads the
//   received word and returns it with a one-cycle rsp_valid pulse.
//   Every output is registered.
//
// Ports
//   clk, reset_n             clock; asynchronous active-low reset
//   req[NUM_REQ]             level request per requester
//   req_slave[NUM_REQ*8]     slave index per requester (8 bits per lane)
//   req_wdata[NUM_REQ*32]    transmit word per requester (32 bits per lane)
//   gnt[NUM_REQ]             one-hot grant pulse
//   rsp_valid/id/rdata/err   completion pulse, winner index, read word,
//                            out-of-range slave flag
//   busy                     high whenever the FSM is not in IDLE
//   avm_*                    Avalon-MM master towards the spi_master
//                            (address 0 = slave select/start, 1 = data)

// Per-requester slave range check.
module spi_req_lane #(
  parameter int NUM_SLAVES = 1
) (
  input  logic [7:0] slave,
  output logic       bad
);
  assign bad = {24'd0, slave} >= 32'(NUM_SLAVES);
endmodule

module spi_request_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int NUM_SLAVES  = 1,
  parameter int XFER_CYCLES = 136
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*8-1:0]       req_slave,
  input  logic [NUM_REQ*32-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [31:0]                rsp_rdata,
  output logic                       rsp_err,
  output logic                       busy,
  output logic [1:0]                 avm_address,
  output logic                       avm_read,
  output logic                       avm_write,
  output logic [31:0]                avm_writedata,
  input  logic [31:0]                avm_readdata
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_SS, WAIT, RD_DATA, CAPTURE
  } state_t;

  // Request captured at grant; in-flight work never looks at req_* again.
  typedef struct packed {
    logic [IDW-1:0] id;
    logic [7:0]     slave;
    logic [31:0]    wdata;
    logic           bad;
  } txn_t;

  logic [NUM_REQ-1:0][7:0]  slave_v;
  logic [NUM_REQ-1:0][31:0] wdata_v;
  logic [NUM_REQ-1:0]       bad_v;

  assign slave_v = req_slave;
  assign wdata_v = req_wdata;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    spi_req_lane #(.NUM_SLAVES(NUM_SLAVES)) u_lane (
      .slave (slave_v[i]),
      .bad   (bad_v[i])
    );
  end

  state_t         state;
  txn_t           cur;
  logic [IDW-1:0] last_winner;
  logic [15:0]    cnt;
  // CAPTURE spends one cycle letting the registered read data arrive.
  logic           cap_ph;

  // Round robin: the first set bit scanning upward from last_winner+1.
  // The loop runs from the far end down, so the nearest candidate is
  // assigned last and wins.
  logic [IDW-1:0] win;
  logic           any;
  always_comb begin
    int j;
    j   = 0;
    win = '0;
    any = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = (int'(last_winner) + k) % NUM_REQ;
      if (req[IDW'(j)]) begin
        win = IDW'(j);
        any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cur           <= '0;
      last_winner   <= IDW'(NUM_REQ - 1);
      cnt           <= '0;
      cap_ph        <= 1'b0;
      gnt           <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      busy          <= 1'b0;
      avm_address   <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            gnt         <= NUM_REQ'(1) << win;
            last_winner <= win;
            cur.id      <= win;
            cur.slave   <= slave_v[win];
            cur.wdata   <= wdata_v[win];
            cur.bad     <= bad_v[win];
            busy        <= 1'b1;
            // An out-of-range slave skips the bus and answers immediately.
            state       <= bad_v[win] ? CAPTURE : WR_DATA;
          end
        end
        WR_DATA: begin
          avm_write     <= 1'b1;
          avm_address   <= 2'd1;
          avm_writedata <= cur.wdata;
          state         <= WR_SS;
        end
        WR_SS: begin
          avm_write     <= 1'b1;
          avm_address   <= 2'd0;
          avm_writedata <= {24'd0, cur.slave};
          cnt           <= 16'(XFER_CYCLES - 1);
          state         <= WAIT;
        end
        WAIT: begin
          // One edge per count value: XFER_CYCLES strobe-free cycles
          // before the read strobe is driven.
          avm_write     <= 1'b0;
          avm_writedata <= '0;
          if (cnt == '0) state <= RD_DATA;
          else           cnt   <= cnt - 16'd1;
        end
        RD_DATA: begin
          avm_read    <= 1'b1;
          avm_address <= 2'd1;
          state       <= CAPTURE;
        end
        CAPTURE: begin
          if (cur.bad) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            rsp_id    <= cur.id;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (!cap_ph) begin
            // The read strobe is on the bus this cycle; data follows next.
            avm_read    <= 1'b0;
            avm_address <= 2'd0;
            cap_ph      <= 1'b1;
          end else begin
            cap_ph    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= avm_readdata;
            rsp_id    <= cur.id;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_request_arbiter.sv
module tb_spi_request_arbiter;
  localparam int NR = 4;
  localparam int NS = 1;
  localparam int XC = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   req;
  logic [31:0]  req_slave;
  logic [127:0] req_wdata;
  logic [3:0]   gnt;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic         busy;
  logic [1:0]   avm_address;
  logic         avm_read;
  logic         avm_write;
  logic [31:0]  avm_writedata;
  logic [31:0]  avm_readdata;
  logic [31:0]  slave_rx;

  spi_request_arbiter #(.NUM_REQ(NR), .NUM_SLAVES(NS), .XFER_CYCLES(XC)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_slave(req_slave),
    .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata)
  );

  always #5 clk = ~clk;

  // spi_master model: registered read data, valid only the cycle after a read.
  always @(posedge clk) avm_readdata <= avm_read ? slave_rx : $urandom;

  int n_tests = 0;
  int n_fail  = 0;
  int m_last  = NR - 1;

  // Observations of the last transaction.
  logic [3:0]  o_gnt;
  int          o_gw, o_lat, o_nwr, o_nrd, o_xgnt;
  bit          o_to, o_both, o_bsy;
  logic [1:0]  o_wa[4];
  logic [31:0] o_wd[4];
  logic [1:0]  o_ra;
  logic [1:0]  o_id;
  logic [31:0] o_rdata;
  logic        o_err;

  // Reference arbiter: walk the rotation order starting after the last winner.
  function automatic int model_pick(input int last, input logic [3:0] r);
    int order[$];
    for (int k = 1; k <= NR; k++) order.push_back((last + k) % NR);
    foreach (order[i]) if (bit'(r >> order[i])) return order[i];
    return -1;
  endfunction

  // Drives one request and records what the DUT does. Starts and ends at a negedge.
  task automatic run_txn(input logic [3:0] r, input logic [31:0] sl,
                         input logic [127:0] wd, input bit hold);
    bit got;
    req = r; req_slave = sl; req_wdata = wd;
    o_nwr = 0; o_nrd = 0; o_xgnt = 0; o_both = 0; o_to = 0; o_gw = 0; o_lat = 0;
    o_gnt = '0; o_ra = '0; o_id = '0; o_rdata = '0; o_err = 1'b0; o_bsy = 1'b0;
    got = 0;
    while (!got && o_gw < 40) begin
      @(negedge clk); o_gw++;
      if (gnt != '0) got = 1;
    end
    if (!got) begin o_to = 1; return; end
    o_gnt = gnt; o_bsy = busy;
    if (!hold) req = '0;
    // Changing inputs after the grant must not disturb the transaction.
    req_slave = $urandom; req_wdata = {$urandom, $urandom, $urandom, $urandom};
    got = 0;
    while (!got && o_lat < XC + 40) begin
      @(negedge clk); o_lat++;
      if (gnt != '0) o_xgnt++;
      if (avm_read && avm_write) o_both = 1;
      if (avm_write && o_nwr < 4) begin
        o_wa[o_nwr] = avm_address; o_wd[o_nwr] = avm_writedata; o_nwr++;
      end
      if (avm_read) begin o_nrd++; o_ra = avm_address; end
      if (rsp_valid) begin got = 1; o_id = rsp_id; o_rdata = rsp_rdata; o_err = rsp_err; end
    end
    if (!got) o_to = 1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; req = '0; req_slave = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({gnt, rsp_valid, rsp_err, rsp_id, rsp_rdata, busy, avm_read, avm_write,
         avm_address, avm_writedata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got gnt=%b v=%b e=%b id=%0d rd=%h busy=%b r=%b w=%b a=%0d wd=%h want all 0",
               gnt, rsp_valid, rsp_err, rsp_id, rsp_rdata, busy, avm_read, avm_write, avm_address, avm_writedata);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({gnt, rsp_valid, busy, avm_read, avm_write} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset got gnt=%b v=%b busy=%b r=%b w=%b want 0", gnt, rsp_valid, busy, avm_read, avm_write);
    end
    m_last = NR - 1;
  endtask

  task automatic test_single;
    logic [127:0] wd;
    wd = '0; wd[64 +: 32] = 32'hA5A5_0001;
    slave_rx = 32'h1234_5678;
    run_txn(4'b0100, 32'd0, wd, 1'b0);
    m_last = 2;
    n_tests++; if (o_to !== 1'b0) begin n_fail++; $display("FAIL single_timeout got %b want 0", o_to); end
    n_tests++; if (o_gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt got %b want 0100", o_gnt); end
    n_tests++; if (o_lat != XC + 5) begin n_fail++; $display("FAIL single_latency got %0d want %0d", o_lat, XC + 5); end
    n_tests++;
    if (o_nwr != 2 || o_wa[0] !== 2'd1 || o_wd[0] !== 32'hA5A5_0001 || o_wa[1] !== 2'd0 || o_wd[1] !== 32'd0) begin
      n_fail++;
      $display("FAIL single_writes got n=%0d (%0d,%h) (%0d,%h) want 2 (1,a5a50001) (0,0)", o_nwr, o_wa[0], o_wd[0], o_wa[1], o_wd[1]);
    end
    n_tests++; if (o_nrd != 1 || o_ra !== 2'd1) begin n_fail++; $display("FAIL single_read got n=%0d a=%0d want 1 a=1", o_nrd, o_ra); end
    n_tests++;
    if (o_id !== 2'd2 || o_rdata !== 32'h1234_5678 || o_err !== 1'b0) begin
      n_fail++; $display("FAIL single_rsp got id=%0d rd=%h e=%b want id=2 rd=12345678 e=0", o_id, o_rdata, o_err);
    end
    n_tests++; if (o_xgnt != 0 || o_both) begin n_fail++; $display("FAIL single_pulses got xgnt=%0d both=%b want 0 0", o_xgnt, o_both); end
  endtask

  task automatic test_contention;
    reset_n = 1'b0; req = '0;
    @(negedge clk); reset_n = 1'b1; m_last = NR - 1;
    for (int t = 0; t < 4; t++) begin
      int exp;
      slave_rx = $urandom;
      exp = model_pick(m_last, 4'b1111);
      run_txn(4'b1111, 32'd0, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
      m_last = exp;
      n_tests++;
      if (o_to || o_gnt !== 4'(1 << t) || o_gnt !== 4'(1 << exp)) begin
        n_fail++; $display("FAIL contention_gnt[%0d] got %b want %b", t, o_gnt, 4'(1 << t));
      end
      n_tests++;
      if (o_rdata !== slave_rx || o_lat != XC + 5) begin
        n_fail++; $display("FAIL contention_rsp[%0d] got rd=%h lat=%0d want rd=%h lat=%0d", t, o_rdata, o_lat, slave_rx, XC + 5);
      end
      if (t > 0) begin
        n_tests++;
        if (o_gw != 1) begin n_fail++; $display("FAIL back_to_back[%0d] got gap=%0d want 1", t, o_gw); end
      end
    end
    req = '0;
  endtask

  task automatic test_rotation;
    logic [3:0] rq[3];
    logic [3:0] want[3];
    rq[0] = 4'b0010; rq[1] = 4'b0011; rq[2] = 4'b0011;
    want[0] = 4'b0010; want[1] = 4'b0001; want[2] = 4'b0010;
    for (int t = 0; t < 3; t++) begin
      int exp;
      slave_rx = $urandom;
      exp = model_pick(m_last, rq[t]);
      run_txn(rq[t], 32'd0, '0, 1'b0);
      m_last = exp;
      n_tests++;
      if (o_to || o_gnt !== want[t] || o_gnt !== 4'(1 << exp)) begin
        n_fail++; $display("FAIL rotation_gnt[%0d] got %b want %b", t, o_gnt, want[t]);
      end
    end
  endtask

  task automatic test_out_of_range;
    int exp;
    exp = model_pick(m_last, 4'b0001);
    run_txn(4'b0001, 32'h0000_0003, {4{32'hFFFF_FFFF}}, 1'b0);
    m_last = exp;
    n_tests++; if (o_to || o_gnt !== 4'b0001) begin n_fail++; $display("FAIL oor_gnt got %b to=%b want 0001", o_gnt, o_to); end
    n_tests++; if (o_lat != 1) begin n_fail++; $display("FAIL oor_latency got %0d want 1", o_lat); end
    n_tests++;
    if (o_err !== 1'b1 || o_rdata !== 32'd0 || o_id !== 2'd0) begin
      n_fail++; $display("FAIL oor_rsp got e=%b rd=%h id=%0d want e=1 rd=0 id=0", o_err, o_rdata, o_id);
    end
    n_tests++; if (o_nwr != 0 || o_nrd != 0) begin n_fail++; $display("FAIL oor_strobes got w=%0d r=%0d want 0 0", o_nwr, o_nrd); end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL oor_idle got busy=%b v=%b want 0 0", busy, rsp_valid); end
  endtask

  task automatic test_reset_mid;
    int c;
    int spurious;
    req = 4'b0100; req_slave = '0; req_wdata = '0;
    c = 0;
    while (gnt == '0 && c < 40) begin @(negedge clk); c++; end
    n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL rstmid_gnt got %b want 0100", gnt); end
    req = '0;
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({gnt, rsp_valid, rsp_err, rsp_id, rsp_rdata, busy, avm_read, avm_write,
         avm_address, avm_writedata} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got v=%b busy=%b r=%b w=%b a=%0d wd=%h want all 0",
               rsp_valid, busy, avm_read, avm_write, avm_address, avm_writedata);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1; m_last = NR - 1;
    spurious = 0;
    repeat (XC + 8) begin @(negedge clk); if (rsp_valid || busy) spurious++; end
    n_tests++; if (spurious != 0) begin n_fail++; $display("FAIL rstmid_silent got %0d active cycles want 0", spurious); end
    slave_rx = 32'hCAFE_0042;
    run_txn(4'b0010, 32'd0, {4{32'h5555_AAAA}}, 1'b0);
    m_last = 1;
    n_tests++;
    if (o_to || o_gnt !== 4'b0010 || o_lat != XC + 5 || o_rdata !== 32'hCAFE_0042 || o_id !== 2'd1) begin
      n_fail++; $display("FAIL rstmid_recover got gnt=%b lat=%0d rd=%h id=%0d want 0010 %0d cafe0042 1",
                         o_gnt, o_lat, o_rdata, o_id, XC + 5);
    end
  endtask

  task automatic test_random;
    for (int t = 0; t < 12; t++) begin
      logic [3:0]   r;
      logic [31:0]  sl;
      logic [127:0] wd;
      int exp;
      bit bad;
      r  = 4'($urandom_range(1, 15));
      for (int l = 0; l < NR; l++) sl[8*l +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      wd = {$urandom, $urandom, $urandom, $urandom};
      slave_rx = $urandom;
      exp = model_pick(m_last, r);
      bad = int'(sl[8*exp +: 8]) >= NS;
      run_txn(r, sl, wd, 1'(($urandom & 1)));
      m_last = exp;
      n_tests++;
      if (o_to || o_gnt !== 4'(1 << exp) || o_bsy !== 1'b1) begin
        n_fail++; $display("FAIL rand_gnt[%0d] got %b busy=%b to=%b want %b busy=1", t, o_gnt, o_bsy, o_to, 4'(1 << exp));
      end
      n_tests++;
      if (o_lat != (bad ? 1 : XC + 5) || o_id !== 2'(exp) || o_err !== bad ||
          o_rdata !== (bad ? 32'd0 : slave_rx)) begin
        n_fail++; $display("FAIL rand_rsp[%0d] got lat=%0d id=%0d e=%b rd=%h want lat=%0d id=%0d e=%b rd=%h",
                           t, o_lat, o_id, o_err, o_rdata, bad ? 1 : XC + 5, exp, bad, bad ? 32'd0 : slave_rx);
      end
      n_tests++;
      if (bad ? (o_nwr != 0 || o_nrd != 0)
              : (o_nwr != 2 || o_wa[0] !== 2'd1 || o_wd[0] !== wd[32*exp +: 32] || o_wa[1] !== 2'd0 ||
                 o_wd[1] !== {24'd0, sl[8*exp +: 8]} || o_nrd != 1 || o_ra !== 2'd1) || o_both || o_xgnt != 0) begin
        n_fail++; $display("FAIL rand_bus[%0d] got w=%0d r=%0d wd0=%h both=%b xgnt=%0d want bad=%b wd0=%h",
                           t, o_nwr, o_nrd, o_wd[0], o_both, o_xgnt, bad, wd[32*exp +: 32]);
      end
    end
    req = '0;
  endtask

  initial begin
    slave_rx = '0;
    test_reset;
    test_single;
    test_contention;
    test_rotation;
    test_out_of_range;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no end of run want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spi_request_arbiter.md
SPI_REQUEST_ARBITER -- requirements
Module: spi_request_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one spi_master, range 2..8.
REQ-002 Parameter NUM_SLAVES, default 1: number of SPI slaves behind the spi_master.
REQ-003 Parameter XFER_CYCLES, default 136: clk cycles waited after the transfer-start write, range 2..65535.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 req  in  NUM_REQ  level request per requester.
REQ-007 req_slave  in  NUM_REQ*8  slave index per requester; requester i uses bits [8i+7:8i].
REQ-008 req_wdata  in  NUM_REQ*32  transmit word per requester; requester i uses bits [32i+31:32i].
REQ-009 gnt  out  NUM_REQ  one-hot, one-cycle grant pulse.
REQ-010 rsp_valid  out  1  one-cycle completion pulse.
REQ-011 rsp_id  out  $clog2(NUM_REQ)  index of the completed requester.
REQ-012 rsp_rdata  out  32  word read back from the spi_master data register.
REQ-013 rsp_err  out  1  qualifies rsp_valid: slave index out of range.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 avm_address  out  2  spi_master register address: 0 = slave select/start, 1 = data.
REQ-016 avm_read / avm_write  out  1 each  Avalon strobes; never both high.
REQ-017 avm_writedata  out  32  write data; avm_readdata  in  32  read data.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 FSM states: IDLE, WR_DATA, WR_SS, WAIT, RD_DATA, CAPTURE.
REQ-020 IDLE with any req bit high: winner = first set bit scanning upward from (last_winner+1) mod NUM_REQ; latch winner's slave and wdata; pulse gnt[winner] for one cycle; update last_winner.
REQ-021 Winner slave index >= NUM_SLAVES: no Avalon access; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0; return to IDLE.
REQ-022 Otherwise, after the grant cycle -> WR_DATA: avm_write=1, avm_address=1, avm_writedata=latched wdata, one cycle.
REQ-023 WR_SS: avm_write=1, avm_address=0, avm_writedata=zero-extended slave index, one cycle; load wait counter with XFER_CYCLES-1.
REQ-024 WAIT: decrement counter each cycle; strobes low; at 0 -> RD_DATA.
REQ-025 RD_DATA: avm_read=1, avm_address=1, one cycle.
REQ-026 avm_readdata SHALL be sampled exactly one cycle after the avm_read cycle (registered spi_master read data).
REQ-027 CAPTURE: rsp_rdata <= avm_readdata, rsp_id <= winner, rsp_err <= 0, rsp_valid pulses one cycle; -> IDLE.
REQ-028 Earliest next grant: the cycle after rsp_valid; no back-to-back overlap of transactions.
REQ-029 Requests deasserted or changed after grant SHALL not affect the transaction in flight.
REQ-030 A requester holding req after its grant SHALL be re-arbitrated normally (fairness by rotation).
REQ-031 Transaction length, grant to rsp_valid, SHALL be exactly XFER_CYCLES+5 cycles.

Reset
REQ-032 reset_n low SHALL immediately force: state IDLE, gnt=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_rdata=0, busy=0, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, last_winner=NUM_REQ-1, counter=0.
REQ-033 Reset mid-transaction SHALL abandon it silently; no rsp_valid is generated for it.

Verification
REQ-034 Single request: req=4'b0100, slave 0, wdata 0xA5A5_0001, XFER_CYCLES=8, model returns 0x1234_5678 -> gnt=4'b0100; writes (1,0xA5A5_0001) then (0,0); read addr 1; rsp_valid 13 cycles after gnt with rsp_id=2, rsp_rdata=0x1234_5678.
REQ-035 Contention: req=4'b1111 held for four transactions from reset -> grant order 0,1,2,3.
REQ-036 Rotation: last_winner=1, req=4'b0011 -> gnt to 0; then req=4'b0011 again -> gnt to 1.
REQ-037 Out-of-range: NUM_SLAVES=1, req_slave=3 -> gnt pulse, next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0, no avm strobes.
REQ-038 Reset during WAIT -> all outputs at reset values next sample, no rsp_valid; a new request after release completes normally.
